// File: rtl/pixel_writer_pkg.sv
// Shared constants for the pixel writer return path: register addresses,
// STATUS bit positions and control-write bit indices.
package pixel_writer_pkg;

  localparam int unsigned PIX_W = 32;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_POPPED = 2'd2;
  localparam logic [1:0] ADDR_IRQ    = 2'd3;

  localparam int unsigned STATUS_DONE_BIT  = 31;
  localparam int unsigned STATUS_UFLOW_BIT = 30;
  localparam int unsigned STATUS_FULL_BIT  = 29;
  localparam int unsigned STATUS_EMPTY_BIT = 28;

  localparam int unsigned CTRL_CLEAR_BIT     = 0;
  localparam int unsigned CTRL_UFLOW_CLR_BIT = 1;

  // Assemble the STATUS register image; unlisted bits read as zero.
  function automatic logic [31:0] pack_status(input logic        done,
                                              input logic        underflow,
                                              input logic        full,
                                              input logic        empty,
                                              input logic [15:0] count);
    logic [31:0] s;
    s                   = '0;
    s[STATUS_DONE_BIT]  = done;
    s[STATUS_UFLOW_BIT] = underflow;
    s[STATUS_FULL_BIT]  = full;
    s[STATUS_EMPTY_BIT] = empty;
    s[15:0]             = count;
    return s;
  endfunction

endpackage

// File: rtl/pixel_writer_if.sv
// Host Avalon-MM slave bus plus the datapath valid/ready pixel conduit.
// The irq wire exists only when PIXEL_WRITER_IRQ_EN is defined.
interface pixel_writer_if;
  import pixel_writer_pkg::*;

  logic [1:0]       address;
  logic             read;
  logic [31:0]      readdata;
  logic             write;
  logic [31:0]      writedata;
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid;
  logic             pix_ready;
  logic             done;
`ifdef PIXEL_WRITER_IRQ_EN
  logic             irq;
`endif

  modport master (
    output address, read, write, writedata, pix_in, pix_valid,
`ifdef PIXEL_WRITER_IRQ_EN
    input  irq,
`endif
    input  readdata, pix_ready, done
  );

  modport slave (
    input  address, read, write, writedata, pix_in, pix_valid,
`ifdef PIXEL_WRITER_IRQ_EN
    output irq,
`endif
    output readdata, pix_ready, done
  );

endinterface

// File: rtl/pixel_sync_fifo.sv
// Single-clock FIFO with combinational head output. Flush has priority over
// push and pop in the same cycle. Count carries one extra bit so a full
// FIFO is distinguishable from an empty one.
module pixel_sync_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Storage array; contents need no reset since empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/pixel_writer_interface.sv
// Return path of the pixel accelerator: buffers datapath pixels in a FIFO
// and exposes DATA/STATUS/POPPED registers to the host over Avalon-MM with
// fixed read latency 1. done rises once FRAME_PIXELS pixels were drained.
// Optional feature macro: PIXEL_WRITER_IRQ_EN adds IRQ_CTRL at address 3
// and a registered irq output.
module pixel_writer_interface
  import pixel_writer_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned FRAME_PIXELS = 1024,
  parameter int unsigned DATA_W       = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  pixel_writer_if.slave  bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [15:0] FRAME_LAST = 16'(FRAME_PIXELS - 1);

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [15:0]       count16;

  logic              push, pop, rd_data, wr_status, clear, uflow_clr;
  logic [31:0]       readdata_q;
  logic [15:0]       popped_q;
  logic              done_q;
  logic              underflow_q;
  logic              unused_wdata;

  assign count16   = 16'(fifo_count);
  assign push      = bus.pix_valid && !fifo_full;
  assign rd_data   = bus.read && (bus.address == ADDR_DATA);
  assign pop       = rd_data && !fifo_empty;
  assign wr_status = bus.write && (bus.address == ADDR_STATUS);
  assign clear     = wr_status && bus.writedata[CTRL_CLEAR_BIT];
  assign uflow_clr = wr_status && bus.writedata[CTRL_UFLOW_CLR_BIT];
  assign unused_wdata = ^bus.writedata;

  pixel_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (clear),
    .din     (bus.pix_in),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

`ifdef PIXEL_WRITER_IRQ_EN
  logic       irq_en_done_q, irq_en_level_q, irq_q;
  logic [7:0] irq_thresh_q;
  logic       wr_irq;

  assign wr_irq = bus.write && (bus.address == ADDR_IRQ);

  // IRQ_CTRL register; not touched by CLEAR.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_en_done_q  <= 1'b0;
      irq_en_level_q <= 1'b0;
      irq_thresh_q   <= '0;
    end else if (wr_irq) begin
      irq_en_done_q  <= bus.writedata[0];
      irq_en_level_q <= bus.writedata[1];
      irq_thresh_q   <= bus.writedata[15:8];
    end
  end

  // Registered interrupt from current done and fill level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (irq_en_done_q && done_q) ||
               (irq_en_level_q && (count16 >= 16'(irq_thresh_q)));
    end
  end

  assign bus.irq = irq_q;
`endif

  // Read data register: loaded on read, holds otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
    end else if (bus.read) begin
      unique case (bus.address)
        ADDR_DATA:   readdata_q <= fifo_empty ? '0 : 32'(fifo_dout);
        ADDR_STATUS: readdata_q <= pack_status(done_q, underflow_q, fifo_full,
                                               fifo_empty, count16);
        ADDR_POPPED: readdata_q <= {16'h0, popped_q};
`ifdef PIXEL_WRITER_IRQ_EN
        ADDR_IRQ:    readdata_q <= {16'h0, irq_thresh_q, 6'h0, irq_en_level_q,
                                    irq_en_done_q};
`else
        ADDR_IRQ:    readdata_q <= '0;
`endif
        default:     readdata_q <= '0;
      endcase
    end
  end

  // Popped counter, done and sticky underflow; CLEAR overrides a coincident pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      popped_q    <= '0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else if (clear) begin
      popped_q    <= '0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (pop && (popped_q != 16'hFFFF)) popped_q <= popped_q + 16'd1;
      if (pop && (popped_q == FRAME_LAST)) done_q <= 1'b1;
      // A fresh underflow wins over a coincident underflow-clear.
      if (rd_data && fifo_empty) underflow_q <= 1'b1;
      else if (uflow_clr)        underflow_q <= 1'b0;
    end
  end

  assign bus.readdata  = readdata_q;
  assign bus.pix_ready = !fifo_full;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_pixel_writer_interface.sv
// Self-checking bench for pixel_writer_interface (DEPTH=16, FRAME_PIXELS=4).
// Table-driven vectors cover basic push/read/status; hand-written sequences
// cover full back-pressure, done, CLEAR, async reset and the optional irq.
module tb_pixel_writer_interface;
  import pixel_writer_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned FRAMES = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  pixel_writer_if bus();

  pixel_writer_interface #(
    .DEPTH        (DEPTH),
    .FRAME_PIXELS (FRAMES),
    .DATA_W       (32)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        push;
    logic [31:0] pix;
    logic        rd;
    logic [1:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic push, input logic [31:0] pix, input logic rd,
                              input logic [1:0] addr, input logic wr,
                              input logic [31:0] wdata, input logic [31:0] exp_rd);
    vec_t v;
    v.push = push; v.pix = pix; v.rd = rd; v.addr = addr;
    v.wr = wr; v.wdata = wdata; v.exp_rd = exp_rd; v.exp_ready = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.read = 1'b0;
    bus.write = 1'b0;
    bus.pix_valid = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(name, d, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] data);
    bus.address = a;
    bus.writedata = data;
    bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic push(input logic [31:0] p);
    int n;
    n = 0;
    bus.pix_in = p;
    bus.pix_valid = 1'b1;
    while (!bus.pix_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.pix_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: pixel 0x%08h not accepted in 50 cycles", p);
    end else begin
      tick();
    end
    bus.pix_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    bus.address = '0;
    bus.writedata = '0;
    bus.pix_in = '0;
    idle();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_readdata", bus.readdata, 32'h0);
    check("reset_done", {31'h0, bus.done}, 32'h0);
    check("reset_ready", {31'h0, bus.pix_ready}, 32'h1);
    reset_n = 1'b1;
    tick();

    // Basic table: push/read/status/underflow/done/clear
    vecs.push_back(mk(1, 32'h11, 0, ADDR_DATA,   0, 0, 0));
    vecs.push_back(mk(1, 32'h22, 0, ADDR_DATA,   0, 0, 0));
    vecs.push_back(mk(1, 32'h33, 0, ADDR_DATA,   0, 0, 0));
    vecs.push_back(mk(0, 0,      1, ADDR_STATUS, 0, 0, 32'h0000_0003));
    vecs.push_back(mk(0, 0,      1, ADDR_DATA,   0, 0, 32'h11));
    vecs.push_back(mk(0, 0,      1, ADDR_DATA,   0, 0, 32'h22));
    vecs.push_back(mk(0, 0,      1, ADDR_DATA,   0, 0, 32'h33));
    vecs.push_back(mk(0, 0,      1, ADDR_STATUS, 0, 0, 32'h1000_0000));
    vecs.push_back(mk(0, 0,      1, ADDR_POPPED, 0, 0, 32'h3));
    vecs.push_back(mk(0, 0,      1, ADDR_IRQ,    0, 0, 32'h0));
    vecs.push_back(mk(0, 0,      1, ADDR_DATA,   0, 0, 32'h0));
    vecs.push_back(mk(0, 0,      1, ADDR_STATUS, 0, 0, 32'h5000_0000));
    vecs.push_back(mk(0, 0,      0, ADDR_STATUS, 1, 32'h2, 0));
    vecs.push_back(mk(0, 0,      1, ADDR_STATUS, 0, 0, 32'h1000_0000));
    vecs.push_back(mk(1, 32'h44, 1, ADDR_DATA,   0, 0, 32'h0));
    vecs.push_back(mk(0, 0,      1, ADDR_STATUS, 0, 0, 32'h4000_0001));
    vecs.push_back(mk(0, 0,      1, ADDR_DATA,   0, 0, 32'h44));
    vecs.push_back(mk(0, 0,      1, ADDR_STATUS, 0, 0, 32'hD000_0000));
    vecs.push_back(mk(0, 0,      0, ADDR_STATUS, 1, 32'h1, 0));
    vecs.push_back(mk(0, 0,      1, ADDR_STATUS, 0, 0, 32'h1000_0000));
    vecs.push_back(mk(0, 0,      1, ADDR_POPPED, 0, 0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      bus.pix_valid = vecs[i].push;
      bus.pix_in    = vecs[i].pix;
      bus.read      = vecs[i].rd;
      bus.write     = vecs[i].wr;
      bus.address   = vecs[i].addr;
      bus.writedata = vecs[i].wdata;
      tick();
      idle();
      if (vecs[i].rd) check($sformatf("vec%0d_readdata", i), bus.readdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_ready", i), {31'h0, bus.pix_ready}, {31'h0, vecs[i].exp_ready});
    end

    // Fill to DEPTH, then hold a pixel against back-pressure
    for (int i = 0; i < DEPTH; i++) push(32'h100 + i);
    check("full_ready_low", {31'h0, bus.pix_ready}, 32'h0);
    rd_check("full_status", ADDR_STATUS, 32'h2000_0010);
    bus.pix_in = 32'hAA;
    bus.pix_valid = 1'b1;
    tick();
    check("held_valid_waits", {31'h0, bus.pix_ready}, 32'h0);
    bus.address = ADDR_DATA;
    bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
    check("full_pop_head", bus.readdata, 32'h100);
    check("ready_after_pop", {31'h0, bus.pix_ready}, 32'h1);
    tick();
    bus.pix_valid = 1'b0;
    check("ready_low_after_refill", {31'h0, bus.pix_ready}, 32'h0);
    rd_check("refill_status", ADDR_STATUS, 32'h2000_0010);
    for (int i = 1; i < DEPTH; i++) rd_check($sformatf("drain%0d", i), ADDR_DATA, 32'h100 + i);
    rd_check("drain_aa", ADDR_DATA, 32'hAA);
    rd_check("drained_status", ADDR_STATUS, 32'h9000_0000);
    rd_check("drained_popped", ADDR_POPPED, 32'd17);
    wr(ADDR_STATUS, 32'h1);

    // Frame of FRAMES pixels: done after the 4th pop, popped keeps counting
    for (int i = 0; i < 6; i++) push(32'h200 + i);
    for (int i = 0; i < 4; i++) begin
      rd_check($sformatf("frame_rd%0d", i), ADDR_DATA, 32'h200 + i);
      check($sformatf("frame_done%0d", i), {31'h0, bus.done}, (i == 3) ? 32'h1 : 32'h0);
    end
    rd_check("frame_popped4", ADDR_POPPED, 32'd4);
    rd_check("frame_rd4", ADDR_DATA, 32'h204);
    rd_check("frame_rd5", ADDR_DATA, 32'h205);
    check("frame_done_held", {31'h0, bus.done}, 32'h1);
    rd_check("frame_popped6", ADDR_POPPED, 32'd6);
    wr(ADDR_STATUS, 32'h1);
    check("clear_done", {31'h0, bus.done}, 32'h0);
    rd_check("clear_popped", ADDR_POPPED, 32'd0);
    rd_check("clear_status", ADDR_STATUS, 32'h1000_0000);

    // CLEAR coincident with a push discards the pixel
    bus.pix_in = 32'h55;
    bus.pix_valid = 1'b1;
    bus.address = ADDR_STATUS;
    bus.writedata = 32'h1;
    bus.write = 1'b1;
    tick();
    idle();
    rd_check("clear_push_status", ADDR_STATUS, 32'h1000_0000);
    rd_check("clear_push_data", ADDR_DATA, 32'h0);
    wr(ADDR_STATUS, 32'h1);

`ifdef PIXEL_WRITER_IRQ_EN
    // Level interrupt at threshold 3
    wr(ADDR_IRQ, 32'h0302);
    rd_check("irq_ctrl_rb", ADDR_IRQ, 32'h0302);
    check("irq_idle", {31'h0, bus.irq}, 32'h0);
    push(32'h401);
    push(32'h402);
    push(32'h403);
    check("irq_lag", {31'h0, bus.irq}, 32'h0);
    tick();
    check("irq_level_hit", {31'h0, bus.irq}, 32'h1);
    rd_check("irq_pop", ADDR_DATA, 32'h401);
    check("irq_still_high", {31'h0, bus.irq}, 32'h1);
    tick();
    check("irq_dropped", {31'h0, bus.irq}, 32'h0);
    wr(ADDR_IRQ, 32'h0);
    wr(ADDR_STATUS, 32'h1);
`endif

    // Async reset mid-stream with a full FIFO
    for (int i = 0; i < DEPTH; i++) push(32'h300 + i);
    rd_check("pre_reset_head", ADDR_DATA, 32'h300);
    push(32'h3AA);
    check("pre_reset_full", {31'h0, bus.pix_ready}, 32'h0);
    reset_n = 1'b0;
    #1;
    check("async_rst_readdata", bus.readdata, 32'h0);
    check("async_rst_done", {31'h0, bus.done}, 32'h0);
    check("async_rst_ready", {31'h0, bus.pix_ready}, 32'h1);
    tick();
    reset_n = 1'b1;
    tick();
    rd_check("post_reset_status", ADDR_STATUS, 32'h1000_0000);
    rd_check("post_reset_popped", ADDR_POPPED, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
